// File: rtl/sd_audio_pkg.sv
// Shared types and width helpers for the sigma-delta audio DAC.
// Latency: none (package only).
// Backpressure: none.
package sd_audio_pkg;

    typedef enum logic [1:0] {
        MUTED     = 2'd0,
        RAMP_UP   = 2'd1,
        TRACK     = 2'd2,
        RAMP_DOWN = 2'd3
    } lvl_state_t;

    // Ceiling log2, intended for elaboration-time constants only
    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

    // Mix width: enough headroom that summing NCH channels never overflows
    function automatic int calc_mw(input int in_w, input int nch);
        return in_w + clog2(nch);
    endfunction

    // Midscale of an mw-bit unsigned level
    function automatic int calc_mid(input int mw);
        return 1 << (mw - 1);
    endfunction

endpackage

// File: rtl/sd_audio_dac_sd_mod.sv
// One sigma-delta modulator turning an MW-bit level into a 1-bit stream.
// Latency: output is registered; runs every clk_i regardless of sample strobes.
// Backpressure: none, free-running.
module sd_mod #(
    parameter int MW    = 8,
    parameter int ORDER = 1
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic [MW-1:0] lvl_i,
    output logic          dout_o
);

    if (ORDER == 1) begin : g_o1
        logic [MW:0] acc_q;
        logic [MW:0] acc_d;

        // Carry out of the phase accumulator is the output bit; the carry is dropped each cycle
        always_comb acc_d = {1'b0, acc_q[MW-1:0]} + {1'b0, lvl_i};

        // Accumulator register
        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) acc_q <= '0;
            else       acc_q <= acc_d;
        end

        assign dout_o = acc_q[MW];
    end else begin : g_o2
        localparam int IW = MW + 4;
        localparam int SW = IW + 2;
        localparam logic signed [SW-1:0] SMAX = {3'b000, {(IW-1){1'b1}}};
        localparam logic signed [SW-1:0] SMIN = {3'b111, {(IW-1){1'b0}}};

        logic signed [IW-1:0] i1_q, i2_q, i1_d, i2_d;
        logic                 dout_q;
        logic signed [SW-1:0] fb, lvl_s, s1, s2;

        // Integrators clamp at their limits so a rail-level input cannot wrap them
        function automatic logic signed [IW-1:0] sat(input logic signed [SW-1:0] v);
            if (v > SMAX)      return {1'b0, {(IW-1){1'b1}}};
            else if (v < SMIN) return {1'b1, {(IW-1){1'b0}}};
            else               return v[IW-1:0];
        endfunction

        // Two cascaded integrators, both fed back with the full-scale output value
        always_comb begin
            lvl_s = $signed({{(SW-MW){1'b0}}, lvl_i});
            fb    = dout_q ? $signed({{(SW-MW){1'b0}}, {MW{1'b1}}}) : '0;
            s1    = $signed({{2{i1_q[IW-1]}}, i1_q}) + lvl_s - fb;
            i1_d  = sat(s1);
            s2    = $signed({{2{i2_q[IW-1]}}, i2_q}) + $signed({{2{i1_d[IW-1]}}, i1_d}) - fb;
            i2_d  = sat(s2);
        end

        // Integrator and comparator registers
        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                i1_q   <= '0;
                i2_q   <= '0;
                dout_q <= 1'b0;
            end else begin
                i1_q   <= i1_d;
                i2_q   <= i2_d;
                dout_q <= ~i2_d[IW-1];
            end
        end

        assign dout_o = dout_q;
    end

endmodule

// File: rtl/sd_audio_dac.sv
// Multi-channel mixer with per-side attenuation, soft-mute ramp and sigma-delta outputs.
// Latency: inputs reach the level on the same sample_ce that latches them; modulators add one clk.
// Backpressure: none; sample_ce is a strobe and every strobe is consumed.
module sd_audio_dac
    import sd_audio_pkg::*;
#(
    parameter int NCH       = 2,
    parameter int IN_W      = 7,
    parameter int SIGNED_IN = 0,
    parameter int ORDER     = 1,
    parameter int RAMP_STEP = 1
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                sample_ce,
    input  logic [NCH*IN_W-1:0] ch_i,
    input  logic [NCH-1:0]      route_l,
    input  logic [NCH-1:0]      route_r,
    input  logic [1:0]          vol_l,
    input  logic [1:0]          vol_r,
    input  logic                mute,
    output logic                dac_l_o,
    output logic                dac_r_o,
    output logic                muted_o
);

    localparam int MW = calc_mw(IN_W, NCH);
    localparam logic [MW-1:0]   MID_V   = MW'(calc_mid(MW));
    localparam logic [MW-1:0]   STEP_V  = MW'(RAMP_STEP);
    localparam logic [IN_W-1:0] HALF_IN = {1'b1, {(IN_W-1){1'b0}}};

    logic [NCH*IN_W-1:0] xin, hold_q, hold_d;
    logic [MW-1:0]       mix_l, mix_r;
    logic [MW-1:0]       tgt     [2];
    logic [MW-1:0]       lvl_q   [2];
    lvl_state_t          state_q [2];

    // Two's complement inputs become offset-binary by flipping the sign bit
    for (genvar k = 0; k < NCH; k++) begin : g_in
        if (SIGNED_IN != 0) begin : g_s
            assign xin[k*IN_W +: IN_W] = {~ch_i[k*IN_W+IN_W-1], ch_i[k*IN_W +: IN_W-1]};
        end else begin : g_u
            assign xin[k*IN_W +: IN_W] = ch_i[k*IN_W +: IN_W];
        end
    end

    // The strobe cycle sees the new samples so the level reacts within the same strobe
    assign hold_d = sample_ce ? xin : hold_q;

    // Sample hold registers, parked at per-channel midscale out of reset
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) hold_q <= {NCH{HALF_IN}};
        else       hold_q <= hold_d;
    end

    // Unrouted channels contribute midscale so the mix stays centred on MID
    always_comb begin
        mix_l = '0;
        mix_r = '0;
        for (int k = 0; k < NCH; k++) begin
            mix_l = mix_l + (route_l[k] ? MW'(hold_d[k*IN_W +: IN_W]) : MW'(HALF_IN));
            mix_r = mix_r + (route_r[k] ? MW'(hold_d[k*IN_W +: IN_W]) : MW'(HALF_IN));
        end
    end

    // Attenuate about midscale: the signed excursion is shifted, then re-centred
    function automatic logic [MW-1:0] atten(input logic [MW-1:0] mix, input logic [1:0] vol);
        logic signed [MW:0] d;
        d = $signed({1'b0, mix}) - $signed({1'b0, MID_V});
        d = d >>> vol;
        d = d + $signed({1'b0, MID_V});
        return d[MW-1:0];
    endfunction

    assign tgt[0] = atten(mix_l, vol_l);
    assign tgt[1] = atten(mix_r, vol_r);

    function automatic logic near(input logic [MW-1:0] cur, input logic [MW-1:0] goal);
        logic [MW-1:0] diff;
        diff = (goal > cur) ? goal - cur : cur - goal;
        return diff <= STEP_V;
    endfunction

    // One ramp step toward goal, landing exactly on it when within a step
    function automatic logic [MW-1:0] toward(input logic [MW-1:0] cur, input logic [MW-1:0] goal);
        if (near(cur, goal))  return goal;
        else if (goal > cur)  return cur + STEP_V;
        else                  return cur - STEP_V;
    endfunction

    // Per-side level FSM; a mute change always wins over ramp completion on the same strobe
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int s = 0; s < 2; s++) begin
                state_q[s] <= MUTED;
                lvl_q[s]   <= MID_V;
            end
        end else if (sample_ce) begin
            for (int s = 0; s < 2; s++) begin
                case (state_q[s])
                    MUTED: begin
                        if (!mute) begin
                            state_q[s] <= RAMP_UP;
                            lvl_q[s]   <= toward(lvl_q[s], tgt[s]);
                        end
                    end
                    RAMP_UP: begin
                        if (mute) begin
                            state_q[s] <= RAMP_DOWN;
                            lvl_q[s]   <= toward(lvl_q[s], MID_V);
                        end else if (near(lvl_q[s], tgt[s])) begin
                            state_q[s] <= TRACK;
                            lvl_q[s]   <= tgt[s];
                        end else begin
                            lvl_q[s]   <= toward(lvl_q[s], tgt[s]);
                        end
                    end
                    TRACK: begin
                        if (mute) begin
                            state_q[s] <= RAMP_DOWN;
                            lvl_q[s]   <= toward(lvl_q[s], MID_V);
                        end else begin
                            lvl_q[s]   <= tgt[s];
                        end
                    end
                    RAMP_DOWN: begin
                        if (!mute) begin
                            state_q[s] <= RAMP_UP;
                            lvl_q[s]   <= toward(lvl_q[s], tgt[s]);
                        end else if (near(lvl_q[s], MID_V)) begin
                            state_q[s] <= MUTED;
                            lvl_q[s]   <= MID_V;
                        end else begin
                            lvl_q[s]   <= toward(lvl_q[s], MID_V);
                        end
                    end
                    default: begin
                        state_q[s] <= MUTED;
                        lvl_q[s]   <= MID_V;
                    end
                endcase
            end
        end
    end

    assign muted_o = (state_q[0] == MUTED) && (state_q[1] == MUTED);

    sd_mod #(.MW(MW), .ORDER(ORDER)) u_mod_l (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .lvl_i  (lvl_q[0]),
        .dout_o (dac_l_o)
    );

    sd_mod #(.MW(MW), .ORDER(ORDER)) u_mod_r (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .lvl_i  (lvl_q[1]),
        .dout_o (dac_r_o)
    );

endmodule
